// File: rtl/uart_pkg.sv
// Shared UART constants: frame length, clear-FSM encodings and the
// oversample divider computation used by RX and TX controllers.
package uart_pkg;

  localparam int unsigned UART_CHAR_BITS = 10;

  localparam logic [2:0] CLR_IDLE  = 3'b001;
  localparam logic [2:0] CLR_CLEAR = 3'b010;
  localparam logic [2:0] CLR_HOLD  = 3'b100;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversamp_rate);
    int unsigned denom;
    denom = baud_rate * oversamp_rate;
    if (denom == 0) return 0;
    return clk_freq / denom;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO with full/empty/level outputs.
// Head word reads as zero while empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_LEVEL);
  assign level = count;

  // A pop frees the slot in the same cycle, so a push at full may proceed.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick, byte capture into a tagged FIFO,
// parity-interrupt clear handshake, idle timeout and sticky status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMP_RATE = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  output logic                          sample_tick_o,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  input  logic                          rx_parity_int_i,
  input  logic                          rx_busy_i,
  output logic                          int_clear_n_o,
  input  logic                          rd_en_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_perr_o,
  output logic                          rd_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
  output logic                          overflow_o,
  output logic                          parity_err_o,
  output logic                          timeout_o,
  input  logic                          status_clear_i
);

  localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMP_RATE);
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TO_LIMIT = TIMEOUT_CHARS * UART_CHAR_BITS * OVERSAMP_RATE;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT);
  localparam logic [TO_W-1:0]  TO_PRE   = TO_W'(TO_LIMIT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_ctrl: CLK_FREQ/(BAUD_RATE*OVERSAMP_RATE) must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick_en;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt <= '0;
      tick_en <= 1'b0;
    end else begin
      tick_en <= enable_i;
      if (!enable_i || div_cnt == DIV_LAST) div_cnt <= '0;
      else                                  div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // tick_en keeps the strobe low after a disable even when DIV is 1.
  assign sample_tick_o = tick_en & (div_cnt == DIV_LAST);

  logic       valid_q;
  logic       push_q;
  logic [8:0] push_word;
  logic       valid_rise;

  assign valid_rise = rx_valid_i & ~valid_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q   <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      valid_q <= rx_valid_i;
      push_q  <= valid_rise;
      if (valid_rise) push_word <= {rx_parity_int_i, rx_data_i};
    end
  end

  logic [8:0] head_word;
  logic       fifo_full;
  logic       pop;
  logic       drop;

  uart_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (reset_n_i),
    .wr_en   (push_q),
    .wr_data (push_word),
    .rd_en   (rd_en_i),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (rd_empty_o),
    .level   (fill_level_o)
  );

  assign rd_data_o = head_word[7:0];
  assign rd_perr_o = head_word[8];
  assign pop       = rd_en_i & ~rd_empty_o;
  assign drop      = push_q & fifo_full & ~pop;

  logic [2:0] clr_state;
  logic [2:0] clr_next;
  logic       perr_set;

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE:  if (rx_parity_int_i) clr_next = CLR_CLEAR;
      CLR_CLEAR: clr_next = CLR_HOLD;
      CLR_HOLD:  clr_next = CLR_IDLE;
      default:   clr_next = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) clr_state <= CLR_IDLE;
    else            clr_state <= clr_next;
  end

  assign int_clear_n_o = (clr_state != CLR_CLEAR);
  assign perr_set      = (clr_state == CLR_IDLE) & rx_parity_int_i;

  logic [TO_W-1:0] to_cnt;
  logic            to_reset;
  logic            to_set;

  assign to_reset = rx_busy_i | push_q | pop | rd_empty_o;
  assign to_set   = ~to_reset & sample_tick_o & (to_cnt == TO_PRE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                              to_cnt <= '0;
    else if (to_reset)                           to_cnt <= '0;
    else if (sample_tick_o && to_cnt != TO_LAST) to_cnt <= to_cnt + TO_ONE;
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o   <= 1'b0;
      parity_err_o <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      if (drop)                overflow_o <= 1'b1;
      else if (status_clear_i) overflow_o <= 1'b0;
      if (perr_set)            parity_err_o <= 1'b1;
      else if (status_clear_i) parity_err_o <= 1'b0;
      if (to_set)              timeout_o <= 1'b1;
      else if (status_clear_i) timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned EXP_DIV  = 50000000 / (115200 * 16);
  localparam int unsigned TO_TICKS = 4 * 10 * 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       sample_tick;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_parity = 1'b0;
  logic       rx_busy = 1'b1;
  logic       int_clear_n;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_empty;
  logic [4:0] fill_level;
  logic       overflow;
  logic       parity_err;
  logic       timeout;
  logic       status_clear = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [8:0] model_q[$];
  logic       m_ov = 1'b0;
  logic       m_pe = 1'b0;
  logic       m_to = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLK_FREQ      (50000000),
    .BAUD_RATE     (115200),
    .OVERSAMP_RATE (16),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CHARS (4)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .enable_i        (enable),
    .sample_tick_o   (sample_tick),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .rx_parity_int_i (rx_parity),
    .rx_busy_i       (rx_busy),
    .int_clear_n_o   (int_clear_n),
    .rd_en_i         (rd_en),
    .rd_data_o       (rd_data),
    .rd_perr_o       (rd_perr),
    .rd_empty_o      (rd_empty),
    .fill_level_o    (fill_level),
    .overflow_o      (overflow),
    .parity_err_o    (parity_err),
    .timeout_o       (timeout),
    .status_clear_i  (status_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ":level"}, 32'(fill_level), 32'(model_q.size()));
    check({tag, ":empty"}, 32'(rd_empty), 32'(model_q.size() == 0));
    if (model_q.size() > 0) begin
      check({tag, ":data"}, 32'(rd_data), 32'(model_q[0][7:0]));
      check({tag, ":perr"}, 32'(rd_perr), 32'(model_q[0][8]));
    end
    check({tag, ":ovf"}, 32'(overflow), 32'(m_ov));
    check({tag, ":perr_sticky"}, 32'(parity_err), 32'(m_pe));
    check({tag, ":tmo"}, 32'(timeout), 32'(m_to));
  endtask

  // One receive strobe; optional status clear and pop land on the write edge.
  task automatic capture(input logic [7:0] d, input logic p, input logic clr, input logic do_pop);
    rx_data = d; rx_valid = 1'b1; rx_parity = p;
    step();
    rx_valid = 1'b0; rx_parity = 1'b0; status_clear = clr; rd_en = do_pop;
    step();
    status_clear = 1'b0; rd_en = 1'b0;
    if (p) begin
      m_pe = 1'b1;
      step();
    end
    if (clr) begin m_ov = 1'b0; m_pe = 1'b0; m_to = 1'b0; end
    if (do_pop && model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back({p, d});
    else                        m_ov = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clear_status();
    status_clear = 1'b1;
    step();
    status_clear = 1'b0;
    m_ov = 1'b0; m_pe = 1'b0; m_to = 1'b0;
  endtask

  // Advance until n ticks have been consumed; report cycles with timeout high.
  task automatic run_ticks(input int unsigned n, output int unsigned seen, output int unsigned hi);
    int unsigned cyc;
    logic t;
    seen = 0; hi = 0; cyc = 0;
    while (seen < n && cyc < n * EXP_DIV + 100) begin
      t = sample_tick;
      step();
      cyc++;
      if (t) seen++;
      if (timeout && seen < n) hi++;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cyc, cnt, seen, hi;
    logic [7:0] first_byte, second_byte;

    repeat (3) step();
    check("rst:tick", 32'(sample_tick), 32'd0);
    check("rst:int_clear_n", 32'(int_clear_n), 32'd1);
    check("rst:rd_data", 32'(rd_data), 32'd0);
    check("rst:rd_perr", 32'(rd_perr), 32'd0);
    check_state("rst");
    reset_n = 1'b1;
    step();

    enable = 1'b1;
    cyc = 0;
    while (!sample_tick && cyc < 60) begin step(); cyc++; end
    check("tick_found", 32'(sample_tick), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("tick_width", 32'(sample_tick), 32'd0);
      cyc = 1;
      while (!sample_tick && cyc < 60) begin step(); cyc++; end
      check("tick_period", cyc, EXP_DIV);
    end
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (sample_tick) cnt++;
    end
    check("tick_disabled", cnt, 0);
    enable = 1'b1;

    capture(8'h55, 1'b0, 1'b0, 1'b0);
    capture(8'hA3, 1'b0, 1'b0, 1'b0);
    capture(8'h0F, 1'b0, 1'b0, 1'b0);
    check("three:level", 32'(fill_level), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_state("three_pop");
      pop_one();
    end
    check("three:empty", 32'(rd_empty), 32'd1);
    check_state("three_done");

    rx_data = 8'h81; rx_valid = 1'b1; rx_parity = 1'b1;
    check("clr_pre", 32'(int_clear_n), 32'd1);
    step();
    check("clr_low", 32'(int_clear_n), 32'd0);
    rx_valid = 1'b0; rx_parity = 1'b0;
    step();
    check("clr_high1", 32'(int_clear_n), 32'd1);
    step();
    check("clr_high2", 32'(int_clear_n), 32'd1);
    model_q.push_back({1'b1, 8'h81});
    m_pe = 1'b1;
    repeat (3) step();
    check_state("parity");
    clear_status();
    check_state("parity_cleared");
    pop_one();

    first_byte  = 8'($urandom);
    second_byte = 8'($urandom);
    capture(first_byte, 1'b0, 1'b0, 1'b0);
    capture(second_byte, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 17; k++) capture(8'($urandom), 1'b0, 1'b0, 1'b0);
    check("full:level", 32'(fill_level), 32'd16);
    check("full:head", 32'(rd_data), 32'(first_byte));
    check_state("overflow");
    capture(8'($urandom), 1'b0, 1'b1, 1'b0);
    check_state("ovf_vs_clear");
    clear_status();
    capture(8'($urandom), 1'b0, 1'b0, 1'b1);
    check("full_pp:head", 32'(rd_data), 32'(second_byte));
    check_state("full_push_pop");
    while (model_q.size() > 0) begin
      check_state("drain");
      pop_one();
    end
    check_state("drained");
    capture(8'($urandom), 1'b0, 1'b0, 1'b1);
    check_state("empty_push_pop");

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: capture(8'($urandom), $urandom_range(0, 3) == 0, 1'b0, 1'b0);
        5, 6:          pop_one();
        7:             capture(8'($urandom), $urandom_range(0, 3) == 0, 1'b0, 1'b1);
        8:             clear_status();
        default:       step();
      endcase
      check_state("rnd");
    end

    while (model_q.size() > 0) pop_one();
    clear_status();
    rx_busy = 1'b0;
    capture(8'h3C, 1'b0, 1'b0, 1'b0);
    run_ticks(TO_TICKS - 1, seen, hi);
    check("tmo:ticks_a", seen, TO_TICKS - 1);
    check("tmo:early", hi, 0);
    check("tmo:before", 32'(timeout), 32'd0);
    run_ticks(1, seen, hi);
    check("tmo:set", 32'(timeout), 32'd1);
    m_to = 1'b1;
    check_state("tmo");
    pop_one();
    clear_status();

    capture(8'hC1, 1'b0, 1'b0, 1'b0);
    capture(8'hC2, 1'b0, 1'b0, 1'b0);
    run_ticks(600, seen, hi);
    check("tmo_pop:early", hi, 0);
    pop_one();
    run_ticks(TO_TICKS - 1, seen, hi);
    check("tmo_pop:ticks", seen, TO_TICKS - 1);
    check("tmo_pop:held_off", hi + 32'(timeout), 0);
    run_ticks(1, seen, hi);
    check("tmo_pop:set", 32'(timeout), 32'd1);
    m_to = 1'b1;
    check_state("tmo_pop");

    rx_busy = 1'b1;
    capture(8'h11, 1'b1, 1'b0, 1'b0);
    capture(8'h22, 1'b0, 1'b0, 1'b0);
    rx_data = 8'h33; rx_valid = 1'b1;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("arst:empty", 32'(rd_empty), 32'd1);
    check("arst:level", 32'(fill_level), 32'd0);
    check("arst:data", 32'(rd_data), 32'd0);
    check("arst:perr", 32'(rd_perr), 32'd0);
    check("arst:flags", {29'd0, overflow, parity_err, timeout}, 32'd0);
    check("arst:int_clear_n", 32'(int_clear_n), 32'd1);
    check("arst:tick", 32'(sample_tick), 32'd0);
    rx_valid = 1'b0;
    model_q.delete();
    m_ov = 1'b0; m_pe = 1'b0; m_to = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_state("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receive datapath (uart_rx_op). It generates the oversample tick, captures each received byte into a small FIFO tagged with its parity status, and runs the parity-interrupt clear handshake. It also detects receive-idle timeouts and exposes sticky status to the host/register side. It sits between uart_rx_op and the system bus glue.

Parameters:
CLK_FREQ, 50000000, clk_i frequency in Hz
BAUD_RATE, 115200, line baud rate
OVERSAMP_RATE, 16, ticks per bit; must match the receiver's value
FIFO_DEPTH, 16, entries; power of two, minimum 2
TIMEOUT_CHARS, 4, idle character times before timeout (1 char = 10 bit times)

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  tick generator enable
sample_tick_o  out  1  one-cycle oversample strobe to the receiver's clk_sample_i
rx_data_i  in  8  receiver data_out_o
rx_valid_i  in  1  receiver data_out_valid_o
rx_parity_int_i  in  1  receiver int_parity_error_o
rx_busy_i  in  1  receiver uart_rx_busy_o
int_clear_n_o  out  1  to receiver int_clear_n_i; active low
rd_en_i  in  1  pop request
rd_data_o  out  8  FIFO head byte, first-word fall-through
rd_perr_o  out  1  parity-error tag of the head byte
rd_empty_o  out  1  FIFO empty
fill_level_o  out  $clog2(FIFO_DEPTH)+1  current entry count
overflow_o  out  1  sticky: byte dropped because FIFO was full
parity_err_o  out  1  sticky: any byte received with a parity error
timeout_o  out  1  sticky: receive idle timeout
status_clear_i  in  1  clears all three sticky flags

Behaviour:
- Reset: sample_tick_o=0, int_clear_n_o=1, rd_empty_o=1, fill_level_o=0, rd_data_o=0, rd_perr_o=0, all sticky flags=0, all counters=0. Assertion mid-frame discards FIFO contents immediately.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMP_RATE), integer division; 27 at the defaults.
  - Counter runs 0..DIV-1. sample_tick_o is high for exactly one cycle when the counter equals DIV-1, and the counter wraps to 0 in that cycle.
  - enable_i=0 forces the counter to 0 and sample_tick_o to 0 on the next edge.
  - DIV<1 is a parameter error and is flagged by an elaboration-time check.
- Capture:
  - A byte is captured on the rising edge of rx_valid_i (registered previous value; 0 to 1 transition). A held-high rx_valid_i captures once.
  - The tag is rx_parity_int_i sampled in the same cycle as the edge.
  - The write lands in the FIFO one cycle after the edge cycle. fill_level_o and rd_empty_o update on that edge.
- FIFO:
  - Stores 9 bits per entry (tag plus data).
  - Pop occurs when rd_en_i=1 and not empty. rd_en_i while empty is ignored with no state change.
  - Push to a full FIFO: the byte is dropped, overflow_o is set, and the contents are unchanged.
  - Simultaneous push and pop when full: both proceed, no overflow, level unchanged.
  - Simultaneous push and pop when empty: the push proceeds and the pop is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Clear FSM (states IDLE, CLEAR, HOLD):
  - IDLE: if rx_parity_int_i=1, go to CLEAR.
  - CLEAR: int_clear_n_o=0 for exactly one cycle, then go to HOLD.
  - HOLD: wait one cycle for the receiver flag to fall, then go to IDLE.
  - parity_err_o is set on entry to CLEAR.
  - If rx_parity_int_i is still high when back in IDLE, the sequence repeats.
- Timeout:
  - A counter of sample_tick_o pulses runs while rx_busy_i=0 and the FIFO is non-empty.
  - It resets on rx_busy_i=1, on any push, on any pop, or when the FIFO is empty.
  - When it reaches TIMEOUT_CHARS*10*OVERSAMP_RATE (640 at the defaults), timeout_o is set and the counter holds until a reset condition occurs.
- Sticky flags: status_clear_i clears all three. A set event in the same cycle as status_clear_i wins, and the flag remains 1.
- Latency: rx_valid_i edge to rd_empty_o=0 is 2 clk_i edges.

Decomposition:
- Shared package uart_pkg holds:
  - frame length constant UART_CHAR_BITS=10
  - the clear-FSM state encodings, one-hot, 3 bits
  - the DIV computation function shared with a future TX controller
- Natural sub-module uart_fifo: a synchronous FWFT FIFO parameterised by WIDTH=9 and DEPTH, with full, empty and level outputs. The tick generator, edge detect, clear FSM and timeout stay in uart_rx_ctrl.

Test Plan:
- Defaults, enable_i=1 -> sample_tick_o pulses every 27 cycles, exactly 1 cycle wide; enable_i=0 -> no pulse within 100 cycles.
- Three valid edges with 0x55, 0xA3, 0x0F, tags 0 -> fill_level_o=3; three pops return 0x55, 0xA3, 0x0F in order, rd_perr_o=0, then rd_empty_o=1.
- 17 captures with DEPTH=16 -> overflow_o=1, level=16, head still the first byte; push and pop in the same cycle at full -> level stays 16, overflow_o unchanged.
- rx_parity_int_i=1 with byte 0x81 -> entry tag 1; int_clear_n_o low for exactly one cycle 1 cycle later; parity_err_o=1 until status_clear_i.
- One byte left unread, rx_busy_i=0 -> timeout_o=1 after the 640th tick; a pop before the 640th tick prevents it.
- reset_n_i asserted mid-capture with a non-empty FIFO -> all outputs return to reset values asynchronously; rd_empty_o=1.
